// File: rtl/sobel_ctrl_pkg.sv
// Shared types for the Sobel frame sequencer: FSM states, coordinate width and
// the delay-line entry that carries pixel metadata alongside the Sobel pipe.
package sobel_ctrl_pkg;

  localparam int CW = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  typedef struct packed {
    logic          valid;
    logic          border;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
  } entry_t;

  // col/row name the newest pixel, so the 3x3 centre sits at (row-1, col-1).
  function automatic logic is_border(input logic [CW-1:0] col, input logic [CW-1:0] row);
    return (col < CW'(2)) || (row < CW'(2));
  endfunction

endpackage

// File: rtl/sobel_ctrl_delay.sv
// PIPE_LAT-deep shift register of pixel metadata, matching the Sobel datapath
// latency so that coordinates line up with the returned Sobel valid.
module sobel_ctrl_delay
  import sobel_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic   iCLK,
  input  logic   iRST,
  input  logic   clr,
  input  entry_t din,
  output entry_t tail
);

  entry_t stage [PIPE_LAT];

  // NOTE: every stage is cleared, not just the valid bits, because a stale
  // valid reaching the tail would be reported as a real output.
  always_ff @(posedge iCLK) begin
    if (!iRST || clr) begin
      for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[PIPE_LAT-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the row buffer + 3x3 Sobel pipe: arms, syncs to SOF,
// gates pixel valid, tracks coordinates and flags border and sync errors.
module sobel_frame_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 2
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iStart,
  input  logic          iContinuous,
  input  logic          iAbort,
  input  logic          iSOF,
  input  logic          iDVAL,
  output logic          oPixDVAL,
  input  logic          iSobelDVAL,
  output logic          oOutVALID,
  output logic          oBorder,
  output logic [CW-1:0] oCol,
  output logic [CW-1:0] oRow,
  output logic          oBusy,
  output logic          oFrameDone,
  output logic          oSyncErr
);

  localparam int            FW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW   = CW'(IMG_H - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(PIPE_LAT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] col, row;
  logic [FW-1:0] flush_cnt;
  logic          early_sof, last_pix, misalign;
  entry_t        head, tail;

  assign early_sof = (state == ACTIVE) && iSOF;
  assign last_pix  = (state == ACTIVE) && iDVAL && !iSOF &&
                     (col == LAST_COL) && (row == LAST_ROW);
  assign misalign  = ((state == ACTIVE) || (state == FLUSH)) && (iSobelDVAL != tail.valid);

  // NOTE: every output and next-state term gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    oPixDVAL   = 1'b0;
    oFrameDone = 1'b0;
    case (state)
      IDLE:   if (iStart) state_nxt = ARMED;
      ARMED:  if (iSOF) state_nxt = ACTIVE;
      ACTIVE: begin
        oPixDVAL = iDVAL;
        if (last_pix) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == LAST_FLUSH) begin
          oFrameDone = 1'b1;
          state_nxt  = iContinuous ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (iAbort) begin
      state_nxt  = IDLE;
      oFrameDone = 1'b0;
    end
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      oSyncErr  <= 1'b0;
    end else begin
      state <= state_nxt;

      // Held at zero while armed so the first pixel after SOF is (0,0).
      if (iAbort || (state == ARMED) || early_sof) begin
        col <= '0;
        row <= '0;
      end else if (oPixDVAL) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if ((state == FLUSH) && (state_nxt == FLUSH)) flush_cnt <= flush_cnt + FW'(1);
      else                                          flush_cnt <= '0;

      if (iStart)                     oSyncErr <= 1'b0;
      else if (early_sof || misalign) oSyncErr <= 1'b1;
    end
  end

  always_comb begin
    head        = '0;
    head.valid  = oPixDVAL;
    head.border = is_border(col, row);
    head.col    = col;
    head.row    = row;
  end

  sobel_ctrl_delay #(
    .PIPE_LAT(PIPE_LAT)
  ) u_delay (
    .iCLK(iCLK),
    .iRST(iRST),
    .clr (iAbort),
    .din (head),
    .tail(tail)
  );

  assign oOutVALID = iSobelDVAL & tail.valid;
  assign oBorder   = tail.valid & tail.border;
  assign oCol      = tail.valid ? tail.col : '0;
  assign oRow      = tail.valid ? tail.row : '0;
  assign oBusy     = (state != IDLE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on an 8x4 frame with a 2-clock Sobel
// stand-in; directed frames push expected outputs, a monitor pops and compares.
module tb_sobel_frame_ctrl;
  import sobel_ctrl_pkg::*;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 4;
  localparam int PIPE_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, cont, abort, sof, dval, miss;
  logic          pix_dval, sobel_dval, out_valid, border, busy, frame_done, sync_err;
  logic [CW-1:0] col, row;

  typedef struct {
    int col;
    int row;
    bit border;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   border_cnt = 0;
  int   done_cnt = 0;
  int   last_cyc = 0;
  int   d0;
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic s1, s2;

  sobel_frame_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst_n),
    .iStart     (start),
    .iContinuous(cont),
    .iAbort     (abort),
    .iSOF       (sof),
    .iDVAL      (dval),
    .oPixDVAL   (pix_dval),
    .iSobelDVAL (sobel_dval),
    .oOutVALID  (out_valid),
    .oBorder    (border),
    .oCol       (col),
    .oRow       (row),
    .oBusy      (busy),
    .oFrameDone (frame_done),
    .oSyncErr   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the conv datapath: returns the gated valid two clocks later.
  always @(posedge clk) begin
    if (!rst_n || abort) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pix_dval;
      s2 <= s1;
    end
  end
  assign sobel_dval = s2 & ~miss;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      out_cnt++;
      if (border) border_cnt++;
      if (sb.size() == 0) begin
        check("sb_unexpected_output", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_border_col_row", {border, col, row},
              {e.border, CW'(e.col), CW'(e.row)});
        check("sb_latency", cyc, e.cyc);
      end
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  function automatic logic [63:0] outs();
    return {pix_dval, out_valid, border, col, row, busy, frame_done, sync_err};
  endfunction

  function automatic void push_exp(input int idx);
    exp_t e;
    e.col    = idx % IMG_W;
    e.row    = (idx / IMG_W) % IMG_H;
    e.border = (e.col < 2) || (e.row < 2);
    e.cyc    = cyc + PIPE_LAT;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit stall, input int miss_idx);
    int idx = 0;
    int ph = 0;
    while (idx < n) begin
      miss = 1'b0;
      if (!stall || pat[ph % 4]) begin
        dval = 1'b1;
        if (idx != miss_idx) push_exp(idx);
        miss = (miss_idx >= 0) && (idx == miss_idx + PIPE_LAT);
        last_cyc = cyc;
        idx++;
      end else begin
        dval = 1'b0;
      end
      ph++;
      if (miss) begin
        @(negedge clk);
        check("miss_outvalid_low", out_valid, 1'b0);
      end
      tick();
    end
    dval = 1'b0;
    miss = 1'b0;
  endtask

  task automatic wait_done(input bit exp_busy);
    int seen = -1;
    for (int i = 0; i < 8 && seen < 0; i++) begin
      @(negedge clk);
      if (frame_done) seen = cyc;
    end
    check("frame_done_cycle", seen, last_cyc + PIPE_LAT);
    @(negedge clk);
    check("busy_after_done", busy, exp_busy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time bound at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    sof = 1'b0; dval = 1'b1; miss = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; dval = 1'b0;
    tick();

    // Full-rate frame sweep
    out_cnt = 0; border_cnt = 0; d0 = done_cnt;
    pulse_start();
    dval = 1'b1;
    @(negedge clk);
    check("armed_busy", busy, 1'b1);
    check("armed_gates_dval", pix_dval, 1'b0);
    @(posedge clk); #1;
    dval = 1'b0;
    pulse_sof();
    send_pixels(32, 1'b0, -1);
    wait_done(1'b0);
    check("sweep_out_cnt", out_cnt, 32);
    check("sweep_border_cnt", border_cnt, 20);
    check("sweep_done_cnt", done_cnt - d0, 1);
    check("sweep_sb_empty", sb.size(), 0);

    // Stalled stream; the pixel coinciding with SOF is not counted
    out_cnt = 0; border_cnt = 0;
    pulse_start();
    sof = 1'b1; dval = 1'b1; tick(); sof = 1'b0; dval = 1'b0;
    send_pixels(32, 1'b1, -1);
    wait_done(1'b0);
    check("stall_out_cnt", out_cnt, 32);
    check("stall_border_cnt", border_cnt, 20);
    check("stall_sb_empty", sb.size(), 0);

    // Continuous mode, two back-to-back frames
    out_cnt = 0; d0 = done_cnt; cont = 1'b1;
    pulse_start();
    pulse_sof();
    send_pixels(32, 1'b0, -1);
    wait_done(1'b1);
    check("cont_no_sync_err", sync_err, 1'b0);
    pulse_sof();
    cont = 1'b0;
    send_pixels(32, 1'b0, -1);
    wait_done(1'b0);
    check("cont_out_cnt", out_cnt, 64);
    check("cont_done_cnt", done_cnt - d0, 2);
    check("cont_sync_err", sync_err, 1'b0);
    check("cont_sb_empty", sb.size(), 0);

    // Early SOF at pixel 13
    pulse_start();
    pulse_sof();
    send_pixels(13, 1'b0, -1);
    pulse_sof();
    @(negedge clk);
    check("early_sof_err", sync_err, 1'b1);
    @(posedge clk); #1;
    send_pixels(32, 1'b0, -1);
    wait_done(1'b0);
    check("early_sof_sb_empty", sb.size(), 0);
    pulse_start();
    @(negedge clk);
    check("start_clears_err", sync_err, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    check("abort_from_armed", busy, 1'b0);
    @(posedge clk); #1;

    // Abort at pixel 10
    d0 = done_cnt;
    pulse_start();
    pulse_sof();
    send_pixels(9, 1'b0, -1);
    dval = 1'b1; tick();
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    check("abort_pix_dval", pix_dval, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    dval = 1'b0;
    repeat (4) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sb_empty", sb.size(), 0);

    // Misaligned Sobel valid on pixel 5
    out_cnt = 0;
    pulse_start();
    pulse_sof();
    @(negedge clk);
    check("misalign_pre_err", sync_err, 1'b0);
    @(posedge clk); #1;
    send_pixels(32, 1'b0, 5);
    check("misalign_err", sync_err, 1'b1);
    wait_done(1'b0);
    check("misalign_out_cnt", out_cnt, 31);
    check("misalign_sb_empty", sb.size(), 0);

    // Reset at pixel 10
    d0 = done_cnt;
    pulse_start();
    pulse_sof();
    send_pixels(9, 1'b0, -1);
    dval = 1'b1; tick();
    rst_n = 1'b0; tick();
    @(negedge clk);
    check("midframe_reset_outputs", outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; dval = 1'b0;
    repeat (4) tick();
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
